// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit.
//   MUL/MULH/MULHSU/MULHU use a 32-step shift-add multiplier.
//   DIV/DIVU/REM/REMU use a 32-step restoring divider.
//   Divide-by-zero and signed overflow complete in 1 cycle; all other ops take 34.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   funct3, a, b          operation and operands, captured at acceptance
//   resp_valid/resp_ready response handshake
//   result                result word, held stable while resp_valid
//   busy                  high whenever the unit is not IDLE
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("muldiv_seq supports XLEN = 32 only");
  end

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpRem    = 3'd6;

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [4:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;    // product accumulator; low half starts as the multiplier
  logic [XLEN-1:0]   r_opb;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_quot;   // dividend bits shift out the top, quotient bits shift in
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_result;

  // ---------------------------------------------------------------------------
  // Acceptance-time decode
  // ---------------------------------------------------------------------------
  logic            w_accept;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_neg_in;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_accept = req_valid && (r_state == StIdle);

  assign w_a_sgn = (funct3 == OpMul) || (funct3 == OpMulh) || (funct3 == OpMulhsu) ||
                   (funct3 == OpDiv) || (funct3 == OpRem);
  assign w_b_sgn = (funct3 == OpMul) || (funct3 == OpMulh) ||
                   (funct3 == OpDiv) || (funct3 == OpRem);

  assign w_a_mag = (w_a_sgn && a[XLEN-1]) ? (~a + 1'b1) : a;
  assign w_b_mag = (w_b_sgn && b[XLEN-1]) ? (~b + 1'b1) : b;

  always_comb begin
    w_neg_in = 1'b0;
    case (funct3)
      OpMul, OpMulh, OpDiv: w_neg_in = a[XLEN-1] ^ b[XLEN-1];
      OpMulhsu, OpRem:      w_neg_in = a[XLEN-1];
      default:              w_neg_in = 1'b0;
    endcase
  end

  assign w_div_zero = funct3[2] && (b == '0);
  assign w_ovf      = ((funct3 == OpDiv) || (funct3 == OpRem)) && (a == MinInt) && (b == '1);
  assign w_fast     = w_div_zero || w_ovf;

  // funct3[1] separates the remainder ops (6, 7) from the quotient ops (4, 5).
  always_comb begin
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = funct3[1] ? a : '1;
    end else begin
      w_fast_res = funct3[1] ? '0 : MinInt;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN:0]     w_rem_shift;  // 33-bit partial remainder for this step
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_quot_next;

  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_acc_next = {w_sum, r_acc[XLEN-1:1]};

  assign w_rem_shift = {r_rem, r_quot[XLEN-1]};
  assign w_trial     = w_rem_shift - {1'b0, r_opb};

  // Restore on a negative trial; a non-negative trial always fits in XLEN bits.
  assign w_rem_next  = w_trial[XLEN] ? w_rem_shift[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quot_next = {r_quot[XLEN-2:0], ~w_trial[XLEN]};

  // ---------------------------------------------------------------------------
  // Sign fix-up and result select
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_res;

  // Negate the full 64-bit product so the high word carries the borrow correctly.
  assign w_prod_fix = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_quot_fix = r_neg ? (~r_quot + 1'b1) : r_quot;
  assign w_rem_fix  = r_neg ? (~r_rem + 1'b1) : r_rem;

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'd0:          w_fix_res = w_prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    w_fix_res = w_quot_fix;
      default:       w_fix_res = w_rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (req_valid) w_state_next = w_fast ? StDone : StCalc;
      StCalc: if (r_cnt == 5'd0) w_state_next = StFix;
      StFix:  w_state_next = StDone;
      StDone: if (resp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op <= funct3;
            if (w_fast) begin
              r_result <= w_fast_res;
            end else begin
              r_neg <= w_neg_in;
              r_cnt <= 5'd31;
              r_opb <= w_b_mag;
              if (funct3[2]) begin
                r_quot <= w_a_mag;
                r_rem  <= '0;
              end else begin
                r_acc <= {{XLEN{1'b0}}, w_a_mag};
              end
            end
          end
        end
        StCalc: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_op[2]) begin
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next;
          end else begin
            r_acc <= w_acc_next;
          end
        end
        StFix: r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == StIdle);
  assign resp_valid = (r_state == StDone);
  assign busy       = (r_state != StIdle);
  assign result     = r_result;

endmodule
